data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: number of 64-bit doublewords stored; power of two.
REQ-002 Parameter LATENCY, default 2: stall cycles per accepted access; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_rd  input  1  read request from the EX/MEM stage.
REQ-006 mem_wr  input  1  write request from the EX/MEM stage.
REQ-007 addr  input  64  byte address (EX/MEM ALU result).
REQ-008 wr_data  input  64  store data.
REQ-009 rd_data  output  64  registered load data to the MEM/WB stage.
REQ-010 rd_valid  output  1  one-cycle pulse: rd_data updated by a completed read.
REQ-011 stall  output  1  holds the upstream pipeline while high.
REQ-012 mem_err  output  1  one-cycle pulse: request rejected.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; 4-bit latency counter.
REQ-014 Request = mem_rd OR mem_wr, sampled only in IDLE; requests seen in BUSY or DONE SHALL be ignored.
REQ-015 Valid request: exactly one of mem_rd/mem_wr high AND addr[2:0] == 0.
REQ-016 Invalid request in IDLE (misaligned, or mem_rd AND mem_wr): mem_err=1 that cycle; stall=0; no access; rd_data unchanged; remain IDLE.
REQ-017 Valid request in IDLE: latch op, word index, wr_data; stall=1 combinationally in the same cycle.
REQ-018 LATENCY=1: IDLE -> DONE; otherwise IDLE -> BUSY, BUSY for LATENCY-1 cycles, then -> DONE.
REQ-019 stall = (IDLE AND valid request) OR BUSY; stall=0 in DONE; total stall cycles per access = LATENCY exactly.
REQ-020 Access SHALL occur on the clock edge entering DONE: write stores latched wr_data; read loads rd_data.
REQ-021 rd_valid=1 in DONE only for reads; 0 for writes.
REQ-022 DONE -> IDLE unconditionally after one cycle; the instruction still presented during DONE SHALL NOT be re-accepted.
REQ-023 Word index = addr[3 +: log2(DEPTH)]; upper address bits ignored (modulo-DEPTH wrap).
REQ-024 rd_data SHALL hold its value until the next completed read.
REQ-025 Read-after-write to the same index in consecutive accesses SHALL return the new data.

Reset
REQ-026 On rst: state=IDLE, counter=0, rd_data=0, rd_valid=0, stall=0, mem_err=0.
REQ-027 Reset SHALL take priority over all activity; reset mid-access (BUSY or DONE-entry edge) SHALL discard the pending access and leave memory unmodified.
REQ-028 Memory array contents SHALL NOT be cleared by reset.
REQ-029 First cycle after rst deasserts SHALL accept a valid request normally.

Verification (LATENCY=2, DEPTH=256)
REQ-030 Write 64'hDEAD_BEEF_0000_0001 to 0x10, then read 0x10 -> stall 1,1,0 for each access; read DONE: rd_data=64'hDEAD_BEEF_0000_0001, rd_valid=1 for one cycle.
REQ-031 Read at 0x13 -> mem_err=1 for one cycle, stall=0, rd_valid=0, rd_data unchanged.
REQ-032 mem_rd=mem_wr=1 at 0x18 -> mem_err=1, stall=0; later read 0x18 returns prior content.
REQ-033 Read held constant across DONE -> exactly one access (stall 1,1,0, single rd_valid pulse); next instruction accepted in the cycle after DONE.
REQ-034 Write 64'h5 to 0x20 with rst asserted in the BUSY cycle -> stall=0 after reset; read 0x20 returns old value.
REQ-035 Write 64'hA5 to 0x808, read 0x8 -> rd_data=64'hA5 (index 257 wraps to 1).

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Single-port data memory controller for the MEM stage. Accepts one
//   aligned doubleword read or write from IDLE, stalls the upstream pipeline
//   for LATENCY cycles, performs the access on the edge that enters DONE,
//   then returns to IDLE. Misaligned or conflicting requests are rejected
//   with a one-cycle mem_err pulse.
//
// Ports
//   clk      in   1   clock, all state on posedge
//   rst      in   1   synchronous active-high reset
//   mem_rd   in   1   read request
//   mem_wr   in   1   write request
//   addr     in  64   byte address; word index = addr[3 +: log2(DEPTH)]
//   wr_data  in  64   store data
//   rd_data  out 64   registered load data, held until the next read completes
//   rd_valid out  1   one-cycle pulse in DONE for a completed read
//   stall    out  1   holds the upstream pipeline
//   mem_err  out  1   one-cycle pulse: request rejected
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [63:0] addr,
  input  logic [63:0] wr_data,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        mem_err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_op_wr;
  logic [IW-1:0]   r_idx;
  logic [63:0]     r_wdata;
  logic [63:0]     r_mem [DEPTH];
  logic [63:0]     r_rd_data;
  logic            r_rd_valid;

  logic            w_req;
  logic            w_valid;
  logic            w_accept;
  logic            w_acc_en;
  logic            w_acc_wr;
  logic [IW-1:0]   w_in_idx;
  logic [IW-1:0]   w_acc_idx;
  logic [63:0]     w_acc_data;
  logic            w_unused_addr;

  assign w_req    = mem_rd | mem_wr;
  assign w_valid  = (mem_rd ^ mem_wr) && (addr[2:0] == 3'b000);
  assign w_in_idx = addr[3 +: IW];

  // Upper address bits are intentionally ignored (modulo-DEPTH wrap).
  assign w_unused_addr = ^addr[63:3+IW];

  // With LATENCY=1 the access happens on the accepting edge itself, so the
  // access operands come straight from the inputs instead of the latches.
  assign w_acc_wr   = (r_state == IDLE) ? mem_wr   : r_op_wr;
  assign w_acc_idx  = (r_state == IDLE) ? w_in_idx : r_idx;
  assign w_acc_data = (r_state == IDLE) ? wr_data  : r_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    stall    = 1'b0;
    mem_err  = 1'b0;
    w_accept = 1'b0;
    w_acc_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_valid) begin
            w_accept = 1'b1;
            stall    = 1'b1;
            if (LATENCY == 1) begin
              w_next   = DONE;
              w_acc_en = 1'b1;
            end else begin
              w_next = BUSY;
            end
          end else begin
            mem_err = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_next   = DONE;
          w_acc_en = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Reset wins: no handshake outputs and no memory side effects.
    if (rst) begin
      w_next   = IDLE;
      stall    = 1'b0;
      mem_err  = 1'b0;
      w_accept = 1'b0;
      w_acc_en = 1'b0;
    end
  end

  // Request latch and latency counter; counter counts BUSY cycles 1..LATENCY-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'd1;
        r_op_wr <= mem_wr;
        r_idx   <= w_in_idx;
        r_wdata <= wr_data;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_acc_en && !w_acc_wr;
      if (w_acc_en && !w_acc_wr) r_rd_data <= r_mem[w_acc_idx];
    end
  end

  // Storage is not reset; w_acc_en is already suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (w_acc_en && w_acc_wr) r_mem[w_acc_idx] <= w_acc_data;
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule
